// File: rtl/hack_data_memory_if.sv
// CPU data port, keyboard handshake and screen scan-out stream of the Hack data memory.
// The master side is the CPU/display/keyboard environment; the memory is the slave.
interface hack_data_memory_if;
  logic [15:0] address_m;
  logic [15:0] out_m;
  logic        write_m;
  logic [15:0] in_m;

  logic [15:0] kbd_code;
  logic        kbd_valid;
  logic        kbd_ready;

  logic [15:0] scan_data;
  logic [12:0] scan_addr;
  logic        scan_valid;
  logic        scan_ready;
  logic        scan_frame_start;

  logic        err_invalid;

  modport master (
    output address_m, out_m, write_m, kbd_code, kbd_valid, scan_ready,
    input  in_m, kbd_ready, scan_data, scan_addr, scan_valid, scan_frame_start, err_invalid
  );

  modport slave (
    input  address_m, out_m, write_m, kbd_code, kbd_valid, scan_ready,
    output in_m, kbd_ready, scan_data, scan_addr, scan_valid, scan_frame_start, err_invalid
  );
endinterface

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen buffer and keyboard register on the CPU M port,
// with a keyboard input handshake and a continuous screen scan-out stream.
module hack_data_memory #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_BASE  = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_ADDR     = 24576
) (
  input logic              clk,
  input logic              reset,
  hack_data_memory_if.slave bus
);
  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [16:0] RAM_END   = 17'(RAM_WORDS);
  localparam logic [16:0] SCR_BEGIN = 17'(SCREEN_BASE);
  localparam logic [16:0] SCR_END   = 17'(SCREEN_BASE + SCREEN_WORDS);
  localparam logic [15:0] KBD_AT    = 16'(KBD_ADDR);
  localparam logic [12:0] SCAN_LAST = 13'(SCREEN_WORDS - 1);

  typedef enum logic [0:0] {KBD_ACCEPT = 1'b0, KBD_HOLD = 1'b1} kbd_state_t;
  typedef enum logic [0:0] {SCAN_IDLE = 1'b0, SCAN_RUN = 1'b1} scan_state_t;

  logic [15:0] ram_r    [0:RAM_WORDS-1];
  logic [15:0] screen_r [0:SCREEN_WORDS-1];

  logic [16:0]       addr_ext_s;
  logic [12:0]       scr_idx_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic              is_ram_s;
  logic              is_scr_s;
  logic              is_kbd_s;
  logic              unmapped_s;
  logic [15:0]       in_m_s;
  logic              err_r;

  kbd_state_t        kbd_state_r;
  kbd_state_t        kbd_next_s;
  logic              kbd_ready_s;
  logic              kbd_take_s;
  logic [15:0]       kbd_reg_r;

  scan_state_t       scan_state_r;
  scan_state_t       scan_next_s;
  logic              scan_valid_s;
  logic              scan_fetch_s;
  logic [12:0]       scan_next_addr_s;
  logic [12:0]       scan_addr_r;
  logic [15:0]       scan_word_r;

  // Address decode of the CPU port into the memory map regions.
  always_comb begin
    addr_ext_s = {1'b0, bus.address_m};
    scr_idx_s  = 13'(bus.address_m - SCR_BEGIN[15:0]);
    ram_idx_s  = bus.address_m[RAM_AW-1:0];
    is_ram_s   = (addr_ext_s < RAM_END);
    is_scr_s   = (addr_ext_s >= SCR_BEGIN) && (addr_ext_s < SCR_END);
    is_kbd_s   = (bus.address_m == KBD_AT);
    unmapped_s = !(is_ram_s || is_scr_s || is_kbd_s);
  end

  // RAM write port; memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.write_m && is_ram_s) begin
      ram_r[ram_idx_s] <= bus.out_m;
    end
  end

  // Screen CPU write port.
  always_ff @(posedge clk) begin
    if (bus.write_m && is_scr_s) begin
      screen_r[scr_idx_s] <= bus.out_m;
    end
  end

  // Combinational CPU read mux; writes become visible only after the edge.
  always_comb begin
    if (is_ram_s) begin
      in_m_s = ram_r[ram_idx_s];
    end else if (is_scr_s) begin
      in_m_s = screen_r[scr_idx_s];
    end else if (is_kbd_s) begin
      in_m_s = kbd_reg_r;
    end else begin
      in_m_s = 16'h0000;
    end
  end

  // Flag writes that land on the read-only keyboard register or outside the map.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= bus.write_m & (is_kbd_s | unmapped_s);
    end
  end

  // Keyboard FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_state_r <= KBD_ACCEPT;
    end else begin
      kbd_state_r <= kbd_next_s;
    end
  end

  // Keyboard FSM next-state logic.
  always_comb begin
    kbd_next_s = KBD_ACCEPT;
    case (kbd_state_r)
      KBD_ACCEPT: begin
        if (bus.kbd_valid) begin
          kbd_next_s = KBD_HOLD;
        end else begin
          kbd_next_s = KBD_ACCEPT;
        end
      end
      KBD_HOLD: kbd_next_s = KBD_ACCEPT;
      default:  kbd_next_s = KBD_ACCEPT;
    endcase
  end

  // Keyboard FSM outputs.
  always_comb begin
    kbd_ready_s = 1'b0;
    kbd_take_s  = 1'b0;
    case (kbd_state_r)
      KBD_ACCEPT: begin
        kbd_ready_s = 1'b1;
        kbd_take_s  = bus.kbd_valid;
      end
      KBD_HOLD: begin
        kbd_ready_s = 1'b0;
        kbd_take_s  = 1'b0;
      end
      default: begin
        kbd_ready_s = 1'b0;
        kbd_take_s  = 1'b0;
      end
    endcase
  end

  // Latched scancode; a key release arrives as an ordinary transfer of code 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_reg_r <= 16'h0000;
    end else if (kbd_take_s) begin
      kbd_reg_r <= bus.kbd_code;
    end else begin
      kbd_reg_r <= kbd_reg_r;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_state_r <= SCAN_IDLE;
    end else begin
      scan_state_r <= scan_next_s;
    end
  end

  // Scan FSM next-state logic: one idle cycle after reset, then run forever.
  always_comb begin
    scan_next_s = SCAN_IDLE;
    case (scan_state_r)
      SCAN_IDLE: scan_next_s = SCAN_RUN;
      SCAN_RUN:  scan_next_s = SCAN_RUN;
      default:   scan_next_s = SCAN_IDLE;
    endcase
  end

  // Scan FSM outputs: when to fetch and which screen word to fetch.
  always_comb begin
    scan_valid_s     = 1'b0;
    scan_fetch_s     = 1'b0;
    scan_next_addr_s = scan_addr_r;
    case (scan_state_r)
      SCAN_IDLE: begin
        scan_valid_s     = 1'b0;
        scan_fetch_s     = 1'b1;
        scan_next_addr_s = 13'd0;
      end
      SCAN_RUN: begin
        scan_valid_s = 1'b1;
        if (bus.scan_ready) begin
          scan_fetch_s = 1'b1;
          if (scan_addr_r == SCAN_LAST) begin
            scan_next_addr_s = 13'd0;
          end else begin
            scan_next_addr_s = scan_addr_r + 13'd1;
          end
        end else begin
          scan_fetch_s     = 1'b0;
          scan_next_addr_s = scan_addr_r;
        end
      end
      default: begin
        scan_valid_s     = 1'b0;
        scan_fetch_s     = 1'b0;
        scan_next_addr_s = 13'd0;
      end
    endcase
  end

  // Presented scan index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_addr_r <= 13'd0;
    end else if (scan_fetch_s) begin
      scan_addr_r <= scan_next_addr_s;
    end else begin
      scan_addr_r <= scan_addr_r;
    end
  end

  // Second screen read port; a stall freezes the word even if the CPU rewrites it.
  always_ff @(posedge clk) begin
    if (scan_fetch_s) begin
      scan_word_r <= screen_r[scan_next_addr_s];
    end
  end

  assign bus.in_m             = in_m_s;
  assign bus.kbd_ready        = kbd_ready_s;
  assign bus.err_invalid      = err_r;
  assign bus.scan_valid       = scan_valid_s;
  assign bus.scan_addr        = scan_addr_r;
  assign bus.scan_data        = scan_valid_s ? scan_word_r : 16'h0000;
  assign bus.scan_frame_start = scan_valid_s && (scan_addr_r == 13'd0);
endmodule
